// File: rtl/event_encoder_8to3_pkg.sv
// Shared types and helpers for the event encoder: default sizing, FSM state
// encoding and a constant-friendly ceil(log2) used to size the code output.
package enc_pkg;

  localparam int N_DEF = 8;
  localparam int W_DEF = 3;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/event_encoder_8to3_if.sv
// Valid/ready code stream carrying the selected event index and its one-hot form.
interface event_encoder_8to3_if #(
  parameter int N = 8,
  parameter int W = 3
);
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_code;
  logic [N-1:0] out_onehot;

  modport master (output out_valid, output out_code, output out_onehot, input out_ready);
  modport slave  (input out_valid, input out_code, input out_onehot, output out_ready);
endinterface

// File: rtl/event_encoder_8to3_pick.sv
// Combinational picker: lowest set bit of vec, or in rr mode the first set bit
// found scanning upward from start+1 with wrap, ending at start itself.
module onehot_prio_pick #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] start,
  input  logic         rr,
  output logic         any,
  output logic [W-1:0] idx
);

  logic found;
  int   j;

  always_comb begin
    any   = |vec;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    if (!rr) begin
      // Descending scan so the lowest set index is the last one written.
      for (int i = N - 1; i >= 0; i--) begin
        if (vec[i]) idx = W'(i);
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        j = int'(start) + k;
        if (j >= N) j = j - N;
        if (!found && vec[j]) begin
          idx   = W'(j);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/event_encoder_8to3.sv
// Event encoder: sticky pending capture of event lines, arbitration, and a
// registered valid/ready stream presenting one binary code per transfer.
//
// state   | meaning
// IDLE    | no code presented; load when enabled and a selectable event is pending
// PRESENT | code held stable on the stream until the consumer accepts it
module event_encoder_8to3
  import enc_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int W       = clog2(N),
  parameter int RR_MODE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [N-1:0]          ev_in,
  input  logic [N-1:0]          ev_mask,
  input  logic                  ovf_clr,
  output logic [N-1:0]          pending,
  output logic [N-1:0]          overflow,
  event_encoder_8to3_if.master  out_if
);

  state_e       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [N-1:0] overflow_q, overflow_d;
  logic [N-1:0] onehot_q, onehot_d;
  logic         valid_q, valid_d;
  logic [W-1:0] code_q, code_d;
  logic [W-1:0] rr_ptr_q, rr_ptr_d;

  logic [N-1:0] new_ev, acc, sel;
  logic [W-1:0] pick_start, pick_idx;
  logic         pick_any, accept;

  onehot_prio_pick #(.N(N), .W(W)) u_pick (
    .vec   (sel),
    .start (pick_start),
    .rr    (RR_MODE != 0),
    .any   (pick_any),
    .idx   (pick_idx)
  );

  always_comb begin
    new_ev     = ev_in & ~ev_mask;
    accept     = valid_q & out_if.out_ready;
    acc        = accept ? onehot_q : '0;
    // The code being accepted is excluded so the next pick is a different event.
    sel        = pending_q & ~ev_mask & ~acc;
    pick_start = accept ? code_q : rr_ptr_q;
    pending_d  = (pending_q & ~acc) | new_ev;
    overflow_d = (overflow_q & ~{N{ovf_clr}}) | (new_ev & pending_q & ~acc);

    state_d  = state_q;
    valid_d  = valid_q;
    code_d   = code_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (enable && pick_any) begin
          code_d  = pick_idx;
          valid_d = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (accept) begin
          rr_ptr_d = code_q;
          if (enable && pick_any) begin
            code_d = pick_idx;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
    onehot_d = valid_d ? (N'(1) << code_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      overflow_q <= '0;
      onehot_q   <= '0;
      valid_q    <= 1'b0;
      code_q     <= '0;
      rr_ptr_q   <= W'(N - 1);
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      onehot_q   <= onehot_d;
      valid_q    <= valid_d;
      code_q     <= code_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign out_if.out_valid  = valid_q;
  assign out_if.out_code   = code_q;
  assign out_if.out_onehot = onehot_q;
  assign pending           = pending_q;
  assign overflow          = overflow_q;

endmodule

// File: tb/tb_event_encoder_8to3.sv
// Bench for event_encoder_8to3: directed scenarios on fixed and round-robin
// instances plus randomized traffic against a cycle-level set/arbitration model.
module tb_event_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst, enable, ovf_clr, ready;
  logic [7:0] ev_in, ev_mask;
  logic [7:0] pending_f, overflow_f, pending_r, overflow_r;

  int tests_run    = 0;
  int tests_failed = 0;

  event_encoder_8to3_if #(.N(8), .W(3)) if_f ();
  event_encoder_8to3_if #(.N(8), .W(3)) if_r ();
  assign if_f.out_ready = ready;
  assign if_r.out_ready = ready;

  event_encoder_8to3 #(.N(8), .W(3), .RR_MODE(0)) u_fix (
    .clk(clk), .rst(rst), .enable(enable), .ev_in(ev_in), .ev_mask(ev_mask),
    .ovf_clr(ovf_clr), .pending(pending_f), .overflow(overflow_f), .out_if(if_f)
  );

  event_encoder_8to3 #(.N(8), .W(3), .RR_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .enable(enable), .ev_in(ev_in), .ev_mask(ev_mask),
    .ovf_clr(ovf_clr), .pending(pending_r), .overflow(overflow_r), .out_if(if_r)
  );

  always #5 clk = ~clk;

  // Reference state per instance: 0 = fixed priority, 1 = round-robin.
  logic [7:0] m_pend[2];
  logic [7:0] m_ovf[2];
  logic       m_valid[2];
  logic [2:0] m_code[2];
  logic [2:0] m_rr[2];

  function automatic void model_update(int d);
    logic [7:0] acc, nw, sel;
    logic [2:0] start;
    logic       accept;
    int         pick;
    if (rst) begin
      m_pend[d] = 8'h00; m_ovf[d] = 8'h00; m_valid[d] = 1'b0;
      m_code[d] = 3'd0;  m_rr[d]  = 3'd7;
      return;
    end
    accept = m_valid[d] & ready;
    acc    = accept ? (8'd1 << m_code[d]) : 8'd0;
    nw     = ev_in & ~ev_mask;
    sel    = m_pend[d] & ~ev_mask & ~acc;
    start  = accept ? m_code[d] : m_rr[d];
    pick   = -1;
    if (d == 0) begin
      for (int i = 0; i < 8; i++) if (pick < 0 && sel[i]) pick = i;
    end else begin
      for (int k = 1; k <= 8; k++) begin
        int jj;
        jj = (int'(start) + k) % 8;
        if (pick < 0 && sel[jj]) pick = jj;
      end
    end
    m_ovf[d]  = (ovf_clr ? 8'h00 : m_ovf[d]) | (nw & m_pend[d] & ~acc);
    m_pend[d] = (m_pend[d] & ~acc) | nw;
    if (accept) m_rr[d] = m_code[d];
    if (!m_valid[d] || accept) begin
      if (enable && pick >= 0) begin
        m_valid[d] = 1'b1;
        m_code[d]  = 3'(pick);
      end else begin
        m_valid[d] = 1'b0;
      end
    end
  endfunction

  task automatic step();
    model_update(0);
    model_update(1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ev_in = 8'h00; ev_mask = 8'h00; enable = 1'b1; ovf_clr = 1'b0; ready = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; ev_in = 8'hFF; ev_mask = 8'h00; enable = 1'b1; ovf_clr = 1'b0; ready = 1'b1;
    step();
    step();
    tests_run++;
    if (pending_f !== 8'h00 || overflow_f !== 8'h00 || if_f.out_valid !== 1'b0 ||
        if_f.out_code !== 3'd0 || if_f.out_onehot !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_fix: pend=%h ovf=%h valid=%b code=%0d onehot=%h, want all zero",
               pending_f, overflow_f, if_f.out_valid, if_f.out_code, if_f.out_onehot);
    end
    tests_run++;
    if (pending_r !== 8'h00 || overflow_r !== 8'h00 || if_r.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_rr: pend=%h ovf=%h valid=%b, want all zero",
               pending_r, overflow_r, if_r.out_valid);
    end
    rst = 1'b0; ev_in = 8'h00; ready = 1'b0;
    step();
  endtask

  task automatic test_single();
    do_reset();
    ready = 1'b1; ev_in = 8'h20;
    step();
    ev_in = 8'h00;
    tests_run++;
    if (if_f.out_valid !== 1'b0 || pending_f !== 8'h20) begin
      tests_failed++;
      $display("FAIL single_latency1: valid=%b pend=%h, want 0 / 20", if_f.out_valid, pending_f);
    end
    step();
    tests_run++;
    if (if_f.out_valid !== 1'b1 || if_f.out_code !== 3'd5 || if_f.out_onehot !== 8'h20) begin
      tests_failed++;
      $display("FAIL single_present: valid=%b code=%0d onehot=%h, want 1 / 5 / 20",
               if_f.out_valid, if_f.out_code, if_f.out_onehot);
    end
    step();
    tests_run++;
    if (if_f.out_valid !== 1'b0 || pending_f !== 8'h00 || if_f.out_onehot !== 8'h00) begin
      tests_failed++;
      $display("FAIL single_after_accept: valid=%b pend=%h onehot=%h, want 0 / 00 / 00",
               if_f.out_valid, pending_f, if_f.out_onehot);
    end
  endtask

  task automatic test_fixed_burst();
    logic [2:0] exp_codes[3];
    exp_codes[0] = 3'd2; exp_codes[1] = 3'd4; exp_codes[2] = 3'd7;
    do_reset();
    ready = 1'b1; ev_in = 8'h94;
    step();
    ev_in = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (if_f.out_valid !== 1'b1 || if_f.out_code !== exp_codes[i]) begin
        tests_failed++;
        $display("FAIL burst_code%0d: valid=%b code=%0d, want 1 / %0d",
                 i, if_f.out_valid, if_f.out_code, exp_codes[i]);
      end
    end
    step();
    tests_run++;
    if (if_f.out_valid !== 1'b0 || pending_f !== 8'h00) begin
      tests_failed++;
      $display("FAIL burst_drain: valid=%b pend=%h, want 0 / 00", if_f.out_valid, pending_f);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    ready = 1'b0; ev_in = 8'h09;
    step();
    ev_in = 8'h00;
    step();
    tests_run++;
    if (if_r.out_valid !== 1'b1 || if_r.out_code !== 3'd0) begin
      tests_failed++;
      $display("FAIL rr_first: valid=%b code=%0d, want 1 / 0", if_r.out_valid, if_r.out_code);
    end
    ready = 1'b1; ev_in = 8'h01;
    step();
    ev_in = 8'h00;
    tests_run++;
    if (if_r.out_code !== 3'd3 || pending_r !== 8'h09) begin
      tests_failed++;
      $display("FAIL rr_after_zero: code=%0d pend=%h, want 3 / 09", if_r.out_code, pending_r);
    end
    step();
    tests_run++;
    if (if_r.out_valid !== 1'b1 || if_r.out_code !== 3'd0) begin
      tests_failed++;
      $display("FAIL rr_wrap: valid=%b code=%0d, want 1 / 0", if_r.out_valid, if_r.out_code);
    end
    step();
    tests_run++;
    if (if_r.out_valid !== 1'b0 || pending_r !== 8'h00) begin
      tests_failed++;
      $display("FAIL rr_drain: valid=%b pend=%h, want 0 / 00", if_r.out_valid, pending_r);
    end
    ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    ready = 1'b0; ev_in = 8'h02;
    step();
    step();
    ev_in = 8'h00;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (if_f.out_valid !== 1'b1 || if_f.out_code !== 3'd1 || overflow_f !== 8'h02) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: valid=%b code=%0d ovf=%h, want 1 / 1 / 02",
                 i, if_f.out_valid, if_f.out_code, overflow_f);
      end
      step();
    end
    ovf_clr = 1'b1;
    step();
    tests_run++;
    if (overflow_f !== 8'h00 || if_f.out_code !== 3'd1) begin
      tests_failed++;
      $display("FAIL bp_ovf_clr: ovf=%h code=%0d, want 00 / 1", overflow_f, if_f.out_code);
    end
    ev_in = 8'h02;
    step();
    ev_in = 8'h00; ovf_clr = 1'b0;
    tests_run++;
    if (overflow_f !== 8'h02) begin
      tests_failed++;
      $display("FAIL bp_set_beats_clr: ovf=%h, want 02", overflow_f);
    end
    ready = 1'b1;
    step();
    tests_run++;
    if (if_f.out_valid !== 1'b0 || pending_f !== 8'h00) begin
      tests_failed++;
      $display("FAIL bp_drain: valid=%b pend=%h, want 0 / 00", if_f.out_valid, pending_f);
    end
    ready = 1'b0;
  endtask

  task automatic test_set_clear();
    do_reset();
    ready = 1'b0; ev_in = 8'h08;
    step();
    ev_in = 8'h00;
    step();
    ready = 1'b1; ev_in = 8'h08;
    step();
    ev_in = 8'h00;
    tests_run++;
    if (pending_f !== 8'h08 || overflow_f !== 8'h00) begin
      tests_failed++;
      $display("FAIL setclr_pending: pend=%h ovf=%h, want 08 / 00", pending_f, overflow_f);
    end
    step();
    tests_run++;
    if (if_f.out_valid !== 1'b1 || if_f.out_code !== 3'd3 || overflow_f !== 8'h00) begin
      tests_failed++;
      $display("FAIL setclr_represent: valid=%b code=%0d ovf=%h, want 1 / 3 / 00",
               if_f.out_valid, if_f.out_code, overflow_f);
    end
    step();
    ready = 1'b0;
  endtask

  task automatic test_random();
    logic       a_valid;
    logic [2:0] a_code;
    logic [7:0] a_onehot, a_pend, a_ovf, e_onehot;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst     = ($urandom_range(0, 299) == 0);
      ev_in   = 8'($urandom & $urandom & $urandom);
      ev_mask = ($urandom_range(0, 3) == 0) ? 8'($urandom & $urandom) : 8'h00;
      enable  = ($urandom_range(0, 9) != 0);
      ready   = ($urandom_range(0, 9) < 7);
      ovf_clr = ($urandom_range(0, 15) == 0);
      step();
      for (int d = 0; d < 2; d++) begin
        a_valid  = (d == 0) ? if_f.out_valid  : if_r.out_valid;
        a_code   = (d == 0) ? if_f.out_code   : if_r.out_code;
        a_onehot = (d == 0) ? if_f.out_onehot : if_r.out_onehot;
        a_pend   = (d == 0) ? pending_f       : pending_r;
        a_ovf    = (d == 0) ? overflow_f      : overflow_r;
        e_onehot = m_valid[d] ? (8'd1 << m_code[d]) : 8'h00;
        tests_run++;
        if (a_valid !== m_valid[d] || a_onehot !== e_onehot || a_pend !== m_pend[d] ||
            a_ovf !== m_ovf[d] || (m_valid[d] && a_code !== m_code[d])) begin
          tests_failed++;
          $display("FAIL random_%s cyc%0d: valid=%b code=%0d onehot=%h pend=%h ovf=%h, want %b / %0d / %h / %h / %h",
                   (d == 0) ? "fix" : "rr", c, a_valid, a_code, a_onehot, a_pend, a_ovf,
                   m_valid[d], m_code[d], e_onehot, m_pend[d], m_ovf[d]);
        end
      end
    end
    rst = 1'b0; ready = 1'b0; ev_in = 8'h00; ev_mask = 8'h00; enable = 1'b1; ovf_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; ovf_clr = 1'b0; ready = 1'b0; ev_in = 8'h00; ev_mask = 8'h00;
    test_reset();
    test_single();
    test_fixed_burst();
    test_round_robin();
    test_backpressure();
    test_set_clear();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
